instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage sitting directly upstream of the single-cycle MIPS core. Owns the fetch PC and requests word-addressed instructions from an instruction memory with a variable-latency request/response handshake. Buffers fetched {pc, instruction} pairs in a small prefetch FIFO and presents them to the core through a valid/ready interface. Core-resolved jumps and branches arrive as a redirect, which flushes the buffer and any in-flight fetch.

## Interface
- DEPTH, 4: prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0: fetch PC after reset
- clock  in  1  sole clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word address of request (PC units: +1 per instruction)
- imem_gnt  in  1  request accepted this cycle (only meaningful when imem_req=1)
- imem_rvalid  in  1  response data valid; exactly one per granted request, ≥1 cycle after gnt
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  core requests PC change (jump, jr, taken branch)
- redirect_pc  in  32  new fetch PC
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  core consumes head this cycle
- instr  out  32  head instruction
- instr_pc  out  32  head PC

## Operation
- FSM states: FETCH, WAIT, DISCARD. At most one request outstanding.
- FETCH: imem_req=1 iff count<DEPTH; imem_addr=fetch_pc. On gnt: fetch_pc<=fetch_pc+1 (mod 2^32, 32'hFFFFFFFF wraps to 0), latch req_pc, go WAIT.
- WAIT: imem_req=0. On rvalid: push {req_pc, imem_rdata}, go FETCH.
- DISCARD: imem_req=0. On rvalid: drop data, go FETCH.
- Redirect (any state, highest priority): FIFO flushed (count<=0), fetch_pc<=redirect_pc.
  - In WAIT, or FETCH with gnt same cycle: go DISCARD.
  - In DISCARD: stay DISCARD (rvalid same cycle still consumed as the stale response, go FETCH).
  - In FETCH without gnt: stay FETCH.
- Redirect + instr_ready same cycle: flush wins; consumed head is not re-presented.
- Redirect + rvalid in WAIT same cycle: data dropped, go FETCH (not DISCARD).
- Push and pop same cycle with FIFO full: cannot occur (request only issued when count<DEPTH, no other outstanding).
- Pop only when instr_valid && instr_ready.
- rvalid in FETCH is a protocol error: ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0; state FETCH, fetch_pc=RESET_PC, count=0.
- imem_req may assert the first clock edge after reset_n deasserts; reset asserted mid-fetch drops everything, and any later stale rvalid must be absorbed by the memory side (memory shares reset).
- imem_req/imem_addr are registered-state decodes; imem_addr stable while imem_req=1 and no gnt.
- Latency: gnt at cycle t, rvalid at t+1 → instr_valid=1 at t+2 (FIFO registered, no bypass).
- Back-to-back throughput with 1-cycle memory: one instruction per 2 cycles (single outstanding).
- Redirect at cycle t → first request for redirect_pc at t+1 (from FETCH) or the cycle after the stale rvalid (from WAIT/DISCARD); instr_valid=0 from t+1 until the new data lands.

## Structure
- Package fetch_pkg: state enum {FETCH, WAIT, DISCARD}, WORD_W=32, default RESET_PC.
- Sub-module fetch_fifo: synchronous DEPTH×64 FIFO with push, pop, flush, count, registered head outputs; flush has priority over push/pop.
- Top: FSM, fetch_pc/req_pc registers, glue (~200 lines total).

## Test plan
- Reset, RESET_PC=0, memory rvalid 1 cycle after gnt, ready=1 → instr_pc sequence 0,1,2,3 with matching imem_rdata, instr_valid first high 2 cycles after first gnt.
- instr_ready=0 held → exactly DEPTH=4 requests issued then imem_req=0; raise ready → heads 0..3 drained in order, fetching resumes at PC 4.
- Redirect to 0x40 while in WAIT for PC 5 → stale rvalid data dropped, next imem_addr=0x40, no PC 5 ever reaches the core.
- Redirect to 0x80 coincident with rvalid and instr_ready → FIFO empty next cycle, next request addr 0x80, no DISCARD entry.
- fetch_pc=32'hFFFFFFFE, run 3 fetches → addresses FFFFFFFE, FFFFFFFF, 0.
- reset_n pulsed low mid-WAIT with 3 FIFO entries → all outputs return to reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory, redirect and core-side handshake bundle of the fetch stage.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [WORD_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} pairs; flush overrides push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output fetch_entry_t           head_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en;
  logic             pop_en;

  assign push_en = push && (count_q < CNT_W'(DEPTH));
  assign pop_en  = pop && (count_q != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues single-outstanding imem requests and
// buffers responses in a prefetch FIFO feeding the core; redirects flush everything.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic                clock,
  input logic                reset_n,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q;
  logic [WORD_W-1:0] fetch_pc_q;
  logic [WORD_W-1:0] req_pc_q;
  logic              req_q;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  next_count;
  logic              granted;
  logic              push;
  logic              pop;
  logic              flush;
  logic              room_next;
  logic              head_valid;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign granted = req_q && bus.imem_gnt;
  assign flush   = bus.redirect_valid;
  assign push    = (state_q == WAIT) && bus.imem_rvalid && !flush;
  assign pop     = head_valid && bus.instr_ready;

  // Occupancy after this edge; the registered request looks one cycle ahead.
  always_comb begin
    next_count = count;
    if (flush) begin
      next_count = '0;
    end else begin
      next_count = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign room_next = (next_count < CNT_W'(DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      req_q      <= 1'b0;
    end else if (flush) begin
      fetch_pc_q <= bus.redirect_pc;
      unique case (state_q)
        FETCH: begin
          // A request granted alongside the redirect still owes a stale response.
          state_q <= granted ? DISCARD : FETCH;
          req_q   <= !granted;
        end
        WAIT, DISCARD: begin
          state_q <= bus.imem_rvalid ? FETCH : DISCARD;
          req_q   <= bus.imem_rvalid;
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b0;
        end
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (granted) begin
            fetch_pc_q <= fetch_pc_q + 32'd1;
            req_pc_q   <= fetch_pc_q;
            state_q    <= WAIT;
            req_q      <= 1'b0;
          end else begin
            req_q <= room_next;
          end
        end
        WAIT, DISCARD: begin
          if (bus.imem_rvalid) begin
            state_q <= FETCH;
            req_q   <= room_next;
          end
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign push_entry = '{pc: req_pc_q, instr: bus.imem_rdata};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head_valid(head_valid),
    .head_data (head)
  );

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory/core stimulus, program-order scoreboard.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Memory model: one response per grant, 1+random cycles later.
  int          gnt_pct  = 100;
  int          min_wait = 0;
  int          max_wait = 0;
  bit          pend     = 1'b0;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          n_grants = 0;
  int          first_gnt_cyc = -1;
  logic [31:0] last_gnt_addr;
  logic [31:0] gnt_log[$];

  initial begin : memory
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.imem_rvalid = 1'b0;
      bus.imem_gnt    = 1'b0;
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (pend_wait == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_addr);
            pend            = 1'b0;
          end else begin
            pend_wait--;
          end
        end
        if (!pend && ($urandom_range(99) < gnt_pct)) begin
          bus.imem_gnt = 1'b1;
          if (bus.imem_req) begin
            pend      = 1'b1;
            pend_addr = bus.imem_addr;
            pend_wait = $urandom_range(max_wait, min_wait);
            if (n_grants == 0) first_gnt_cyc = cyc;
            n_grants++;
            last_gnt_addr = bus.imem_addr;
            gnt_log.push_back(bus.imem_addr);
          end
        end
      end
    end
  end

  // Scoreboard: the core must see consecutive PCs from the last reset or redirect.
  logic [31:0] exp_q[$];
  logic [31:0] nxt_pc = RESET_PC;
  int          n_pops = 0;
  bit          prev_ok = 1'b0, prev_req, prev_gnt, prev_redir;
  logic [31:0] prev_addr;

  task automatic restart_stream(input logic [31:0] pc);
    exp_q.delete();
    nxt_pc = pc;
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        restart_stream(RESET_PC);
        prev_ok = 1'b0;
      end else begin
        if (prev_ok && prev_req && !prev_gnt && !prev_redir) begin
          check("req_held", bus.imem_req, 1'b1);
          check("addr_stable", bus.imem_addr, prev_addr);
        end
        if (bus.instr_valid && bus.instr_ready) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back(nxt_pc);
            nxt_pc = nxt_pc + 32'd1;
          end
          e = exp_q.pop_front();
          check("head_pc", bus.instr_pc, e);
          check("head_instr", bus.instr, mem_word(e));
          n_pops++;
        end
        if (bus.redirect_valid) restart_stream(bus.redirect_pc);
        prev_ok    = 1'b1;
        prev_req   = bus.imem_req;
        prev_gnt   = bus.imem_gnt;
        prev_redir = bus.redirect_valid;
        prev_addr  = bus.imem_addr;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    n_grants      = 0;
    first_gnt_cyc = -1;
    gnt_log.delete();
    step(1);
    reset_n = 1'b1;
  endtask

  task automatic wait_grants(input int target, input string name);
    int k;
    for (k = 0; k < 60 && n_grants < target; k++) step(1);
    check(name, 32'(n_grants >= target), 32'd1);
  endtask

  initial begin : main
    int k, p0, g0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset values, first-fetch latency and steady-state throughput.
    step(2);
    check("rst_imem_req", bus.imem_req, 1'b0);
    check("rst_imem_addr", bus.imem_addr, RESET_PC);
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);
    do_reset();
    bus.instr_ready = 1'b1;
    for (k = 0; k < 20 && !bus.instr_valid; k++) step(1);
    check("first_valid_seen", bus.instr_valid, 1'b1);
    check("first_valid_latency", 32'(cyc - first_gnt_cyc), 32'd2);
    step(6);
    p0 = n_pops;
    step(16);
    check("throughput_16cyc", 32'(n_pops - p0), 32'd8);

    // Core stalled: exactly DEPTH requests, then drain and resume at PC 4.
    bus.instr_ready = 1'b0;
    do_reset();
    step(24);
    check("full_grants", 32'(n_grants), DEPTH);
    check("full_req_low", bus.imem_req, 1'b0);
    check("full_valid", bus.instr_valid, 1'b1);
    p0 = n_pops;
    bus.instr_ready = 1'b1;
    wait_grants(DEPTH + 1, "resume_grant");
    check("resume_addr", last_gnt_addr, 32'd4);
    step(10);
    check("drained", 32'(n_pops - p0 >= 4), 32'd1);

    // Redirect to 0x40 while waiting on PC 5.
    do_reset();
    min_wait = 1;
    max_wait = 1;
    for (k = 0; k < 100 && !(pend && pend_addr == 32'd5 && !bus.imem_req); k++) step(1);
    check("wait_pc5_found", 32'(k < 100), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    step(1);
    bus.redirect_valid = 1'b0;
    check("redir_wait_valid", bus.instr_valid, 1'b0);
    check("redir_wait_discard", bus.imem_req, 1'b0);
    step(1);
    check("redir_wait_req", bus.imem_req, 1'b1);
    check("redir_wait_addr", bus.imem_addr, 32'h40);
    check("redir_wait_gnt", last_gnt_addr, 32'h40);
    p0 = n_pops;
    step(20);
    check("redir_wait_progress", 32'(n_pops > p0), 32'd1);

    // Redirect to 0x80 together with rvalid and instr_ready.
    bus.instr_ready = 1'b0;
    min_wait = 0;
    max_wait = 0;
    do_reset();
    for (k = 0; k < 40 && !(bus.imem_rvalid && n_grants == 2); k++) step(1);
    check("coinc_found", 32'(k < 40), 32'd1);
    check("coinc_head_valid", bus.instr_valid, 1'b1);
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    step(1);
    bus.redirect_valid = 1'b0;
    check("coinc_empty", bus.instr_valid, 1'b0);
    check("coinc_req", bus.imem_req, 1'b1);
    check("coinc_addr", bus.imem_addr, 32'h80);
    step(12);

    // PC wrap-around.
    do_reset();
    gnt_pct = 0;
    step(4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    step(1);
    bus.redirect_valid = 1'b0;
    gnt_log.delete();
    gnt_pct = 100;
    for (k = 0; k < 40 && gnt_log.size() < 3; k++) step(1);
    check("wrap_grants", 32'(gnt_log.size() >= 3), 32'd1);
    if (gnt_log.size() >= 3) begin
      check("wrap_addr0", gnt_log[0], 32'hFFFF_FFFE);
      check("wrap_addr1", gnt_log[1], 32'hFFFF_FFFF);
      check("wrap_addr2", gnt_log[2], 32'h0000_0000);
    end
    step(8);

    // Asynchronous reset mid-WAIT with three buffered entries.
    bus.instr_ready = 1'b0;
    min_wait = 2;
    max_wait = 2;
    do_reset();
    for (k = 0; k < 60 && !(n_grants == 4 && pend && !bus.imem_req); k++) step(1);
    check("midwait_found", 32'(k < 60), 32'd1);
    check("midwait_valid", bus.instr_valid, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_req", bus.imem_req, 1'b0);
    check("async_rst_addr", bus.imem_addr, RESET_PC);
    check("async_rst_valid", bus.instr_valid, 1'b0);
    check("async_rst_instr", bus.instr, 32'h0);
    check("async_rst_pc", bus.instr_pc, 32'h0);
    step(2);
    reset_n = 1'b1;
    g0 = n_grants;
    bus.instr_ready = 1'b1;
    wait_grants(g0 + 1, "restart_grant");
    check("restart_addr", last_gnt_addr, RESET_PC);
    step(10);

    // Random traffic against the program-order scoreboard.
    do_reset();
    min_wait = 0;
    max_wait = 3;
    p0 = n_pops;
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 0) gnt_pct = 40 + $urandom_range(60);
      bus.instr_ready    = ($urandom_range(99) < 70);
      bus.redirect_valid = ($urandom_range(99) < 4);
      if ($urandom_range(3) == 0) bus.redirect_pc = 32'hFFFF_FFFC + $urandom_range(3);
      else bus.redirect_pc = $urandom;
      step(1);
    end
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    step(20);
    check("random_progress", 32'(n_pops - p0 > 200), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
